// File: rtl/knight_seq_pkg.sv
// Shared types and constants for the Knight's Tour command sequencer.
package knight_seq_pkg;

    // Playback controller states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_SENT,
        S_WAIT_RESP,
        S_GAP,
        S_END
    } state_t;

    // Run outcome reported on err.
    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_TMO      = 2'b01,
        ERR_MISMATCH = 2'b10,
        ERR_ABORT    = 2'b11
    } err_t;

    // Default RemoteComm command width; the entry layout below matches it.
    localparam int ENTRY_CMD_W = 16;

    // One queue entry as presented on wr_data: command in the upper bits,
    // the response byte it should produce in the low byte.
    typedef struct packed {
        logic [ENTRY_CMD_W-1:0] cmd;
        logic [7:0]             exp_resp;
    } entry_t;

    // Acknowledge byte returned by KnightPhysics for a well-formed command.
    localparam logic [7:0] RESP_ACK = 8'hA5;

    // Larger of two counts, used to size the shared timer.
    function automatic int max_cnt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/knight_cmd_sequencer_seq_timer.sv
// Loadable down-counter shared by the response timeout and the inter-command gap.
module seq_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt;

    // Load wins over counting; the counter parks at zero once it gets there.
    // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/knight_cmd_sequencer.sv
// Command player: replays a small queue of {cmd, expected response} entries
// into RemoteComm, checks each reply and reports pass/fail and the failing index.
module knight_cmd_sequencer
    import knight_seq_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int CMD_W   = 16,
    parameter int TMO_CYC = 10_000_000,
    parameter int GAP_CYC = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [CMD_W+7:0]         wr_data,
    input  logic                     clr,
    input  logic                     start,
    input  logic                     abort,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CMD_W-1:0]         cmd,
    output logic                     send_cmd,
    input  logic                     cmd_sent,
    input  logic                     resp_rdy,
    input  logic [7:0]               resp,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [1:0]               err,
    output logic [$clog2(DEPTH)-1:0] fail_idx
);

    localparam int AW    = $clog2(DEPTH);
    localparam int TMR_W = $clog2(max_cnt(TMO_CYC, GAP_CYC) + 1);

    // The timer counts down to zero inclusive, so a window of N cycles loads N-1.
    localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TMO_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t             state;
    logic [AW-1:0]      ptr;
    logic [CMD_W+7:0]   queue_q [DEPTH];
    logic [CMD_W+7:0]   cur_entry;
    logic [CMD_W-1:0]   cur_cmd;
    logic [7:0]         cur_exp;
    logic               is_last;
    logic               resp_ok;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_en;
    logic               tmr_expired;
    logic               wr_accept;

    assign full      = (count == (AW + 1)'(DEPTH));
    assign wr_accept = wr_en && !clr && !full && !busy;

    assign cur_entry = queue_q[ptr];
    assign cur_cmd   = cur_entry[CMD_W+7:8];
    assign cur_exp   = cur_entry[7:0];
    assign resp_ok   = (resp == cur_exp);
    assign is_last   = ({1'b0, ptr} == (count - 1'b1));

    // Queue storage: plain flops written at the current fill level.
    // NOTE: the entry array has no reset; count returns to 0 so stale entries are never read.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            queue_q[count[AW-1:0]] <= wr_data;
        end
    end

    // Fill level: clr beats wr_en, and the queue is frozen during playback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!busy) begin
            if (clr) begin
                count <= '0;
            end else if (wr_accept) begin
                count <= count + 1'b1;
            end
        end
    end

    // Timer control: arm the timeout on every entry into ISSUE, the gap on an accepted reply.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = TMO_LOAD;
        unique case (state)
            S_IDLE: begin
                if (start && (count != '0)) begin
                    tmr_load = 1'b1;
                end
            end
            S_GAP: begin
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                end
            end
            S_WAIT_SENT, S_WAIT_RESP: begin
                if (resp_rdy && resp_ok && !is_last) begin
                    tmr_load = 1'b1;
                    if (GAP_CYC > 0) begin
                        tmr_val = GAP_LOAD;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign tmr_en = (state == S_ISSUE) || (state == S_WAIT_SENT) ||
                    (state == S_WAIT_RESP) || (state == S_GAP);

    seq_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    // Playback FSM with registered outputs; abort pre-empts everything while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ptr      <= '0;
            cmd      <= '0;
            send_cmd <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err      <= ERR_NONE;
            fail_idx <= '0;
        end else begin
            send_cmd <= 1'b0;
            if (abort && (state != S_IDLE) && (state != S_END)) begin
                state    <= S_END;
                busy     <= 1'b0;
                done     <= 1'b1;
                pass     <= 1'b0;
                err      <= ERR_ABORT;
                fail_idx <= ptr;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            ptr      <= '0;
                            pass     <= 1'b0;
                            err      <= ERR_NONE;
                            fail_idx <= '0;
                            if (count == '0) begin
                                state <= S_END;
                                done  <= 1'b1;
                                pass  <= 1'b1;
                            end else begin
                                state <= S_ISSUE;
                                busy  <= 1'b1;
                                done  <= 1'b0;
                            end
                        end
                    end
                    S_ISSUE: begin
                        cmd      <= cur_cmd;
                        send_cmd <= 1'b1;
                        state    <= S_WAIT_SENT;
                    end
                    S_WAIT_SENT, S_WAIT_RESP: begin
                        // An early reply (before or with cmd_sent) is judged right away.
                        if (resp_rdy) begin
                            if (!resp_ok) begin
                                state    <= S_END;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                err      <= ERR_MISMATCH;
                                fail_idx <= ptr;
                            end else if (is_last) begin
                                state <= S_END;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                pass  <= 1'b1;
                            end else begin
                                ptr   <= ptr + 1'b1;
                                state <= (GAP_CYC == 0) ? S_ISSUE : S_GAP;
                            end
                        end else if (tmr_expired) begin
                            state    <= S_END;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            err      <= ERR_TMO;
                            fail_idx <= ptr;
                        end else if ((state == S_WAIT_SENT) && cmd_sent) begin
                            state <= S_WAIT_RESP;
                        end
                    end
                    S_GAP: begin
                        if (tmr_expired) begin
                            state <= S_ISSUE;
                        end
                    end
                    S_END: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_knight_cmd_sequencer.sv
// Directed bench for knight_cmd_sequencer with a small RemoteComm/KnightPhysics responder.
module tb_knight_cmd_sequencer;
    import knight_seq_pkg::*;

    localparam int DEPTH   = 4;
    localparam int CMD_W   = 16;
    localparam int TMO_CYC = 1000;
    localparam int GAP_CYC = 16;
    localparam int AW      = $clog2(DEPTH);

    logic                 clk;
    logic                 rst_n;
    logic                 wr_en;
    logic [CMD_W+7:0]     wr_data;
    logic                 clr;
    logic                 start;
    logic                 abort;
    logic                 full;
    logic [AW:0]          count;
    logic [CMD_W-1:0]     cmd;
    logic                 send_cmd;
    logic                 cmd_sent;
    logic                 resp_rdy;
    logic [7:0]           resp;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [1:0]           err;
    logic [AW-1:0]        fail_idx;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Responder / monitor state
    int          n_sent   = 0;
    int          rsp_idx  = 0;
    logic        rsp_on   = 1'b0;
    int          abort_at = -1;
    logic [15:0] sent_cmd [16];
    int          sent_t   [16];
    logic [15:0] tour_cmd [4];

    knight_cmd_sequencer #(
        .DEPTH   (DEPTH),
        .CMD_W   (CMD_W),
        .TMO_CYC (TMO_CYC),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .clr      (clr),
        .start    (start),
        .abort    (abort),
        .full     (full),
        .count    (count),
        .cmd      (cmd),
        .send_cmd (send_cmd),
        .cmd_sent (cmd_sent),
        .resp_rdy (resp_rdy),
        .resp     (resp),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err      (err),
        .fail_idx (fail_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Responder: logs every send_cmd, then acks with cmd_sent and an A5 reply.
    initial begin
        cmd_sent = 1'b0;
        resp_rdy = 1'b0;
        resp     = 8'h00;
        abort    = 1'b0;
        forever begin
            @(negedge clk);
            if (send_cmd) begin
                rsp_idx = n_sent;
                if (n_sent < 16) begin
                    sent_cmd[n_sent] = cmd;
                    sent_t[n_sent]   = cyc;
                end
                n_sent++;
                if (rsp_on) begin
                    repeat (3) @(negedge clk);
                    cmd_sent = 1'b1;
                    @(negedge clk);
                    cmd_sent = 1'b0;
                    repeat (2) @(negedge clk);
                    resp     = RESP_ACK;
                    resp_rdy = 1'b1;
                    if (rsp_idx == abort_at) abort = 1'b1;
                    @(negedge clk);
                    resp_rdy = 1'b0;
                    abort    = 1'b0;
                end
            end
        end
    end

    task automatic load_entry(input logic [15:0] c, input logic [7:0] e);
        entry_t ent;
        ent.cmd      = c;
        ent.exp_resp = e;
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = ent;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic start_run(output int t0);
        @(negedge clk);
        n_sent = 0;
        t0     = cyc;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int t_done);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        t_done = cyc;
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        int t0;
        int td;
        int k;
        tour_cmd[0] = 16'h2000;
        tour_cmd[1] = 16'h4001;
        tour_cmd[2] = 16'h4401;
        tour_cmd[3] = 16'h4801;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        clr     = 1'b0;
        start   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_count",    32'(count),    32'd0);
        check("rst_full",     32'(full),     32'd0);
        check("rst_cmd",      32'(cmd),      32'd0);
        check("rst_send",     32'(send_cmd), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_pass",     32'(pass),     32'd0);
        check("rst_err",      32'(err),      32'd0);
        check("rst_fail_idx", 32'(fail_idx), 32'd0);

        // Empty queue: immediate pass, nothing sent
        start_run(t0);
        wait_done("empty", 10, td);
        repeat (5) @(negedge clk);
        check("empty_pass",  32'(pass),   32'd1);
        check("empty_err",   32'(err),    32'd0);
        check("empty_sends", 32'(n_sent), 32'd0);
        check("empty_busy",  32'(busy),   32'd0);

        // Fill to DEPTH, then one more that must be dropped
        for (int i = 0; i < 4; i++) load_entry(tour_cmd[i], RESP_ACK);
        check("fill_count", 32'(count), 32'd4);
        check("fill_full",  32'(full),  32'd1);
        load_entry(16'h4C01, RESP_ACK);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_full",  32'(full),  32'd1);

        // Passing tour: cmd order, start latency and spacing between issues
        rsp_on   = 1'b1;
        abort_at = -1;
        start_run(t0);
        check("run_busy", 32'(busy), 32'd1);
        load_entry(16'hDEAD, 8'h00);
        check("run_wr_dropped", 32'(count), 32'd4);
        wait_done("pass", 400, td);
        check("pass_pass",     32'(pass),     32'd1);
        check("pass_err",      32'(err),      32'd0);
        check("pass_fail_idx", 32'(fail_idx), 32'd0);
        check("pass_busy",     32'(busy),     32'd0);
        check("pass_sends",    32'(n_sent),   32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("pass_cmd%0d", i), 32'(sent_cmd[i]), 32'(tour_cmd[i]));
        check("pass_latency", 32'(sent_t[0] - t0), 32'd2);
        for (int i = 1; i < 4; i++)
            check($sformatf("pass_spacing%0d", i), 32'(sent_t[i] - sent_t[i-1]), 32'(GAP_CYC + 8));

        // Replay without reload; a start while busy must be ignored
        start_run(t0);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("replay", 400, td);
        check("replay_pass",  32'(pass),   32'd1);
        check("replay_sends", 32'(n_sent), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("replay_cmd%0d", i), 32'(sent_cmd[i]), 32'(tour_cmd[i]));

        // Mismatch on entry 1
        do_clr();
        check("clr_count", 32'(count), 32'd0);
        check("clr_full",  32'(full),  32'd0);
        load_entry(tour_cmd[0], RESP_ACK);
        load_entry(tour_cmd[1], 8'h5A);
        load_entry(tour_cmd[2], RESP_ACK);
        load_entry(tour_cmd[3], RESP_ACK);
        start_run(t0);
        wait_done("mism", 400, td);
        repeat (60) @(negedge clk);
        check("mism_done",     32'(done),     32'd1);
        check("mism_pass",     32'(pass),     32'd0);
        check("mism_err",      32'(err),      32'(ERR_MISMATCH));
        check("mism_fail_idx", 32'(fail_idx), 32'd1);
        check("mism_sends",    32'(n_sent),   32'd2);

        // Abort together with the reply to entry 2
        do_clr();
        for (int i = 0; i < 4; i++) load_entry(tour_cmd[i], RESP_ACK);
        abort_at = 2;
        start_run(t0);
        wait_done("abort", 400, td);
        repeat (30) @(negedge clk);
        abort_at = -1;
        check("abort_err",      32'(err),      32'(ERR_ABORT));
        check("abort_fail_idx", 32'(fail_idx), 32'd2);
        check("abort_pass",     32'(pass),     32'd0);
        check("abort_sends",    32'(n_sent),   32'd3);

        // Silent responder: timeout lands exactly TMO_CYC cycles after ISSUE
        rsp_on = 1'b0;
        start_run(t0);
        wait_done("tmo", 1200, td);
        check("tmo_end_cycle", 32'(td - t0), 32'(TMO_CYC + 1));
        check("tmo_err",       32'(err),      32'(ERR_TMO));
        check("tmo_fail_idx",  32'(fail_idx), 32'd0);
        check("tmo_pass",      32'(pass),     32'd0);
        check("tmo_sends",     32'(n_sent),   32'd1);

        // Async reset in the middle of a run
        rsp_on = 1'b1;
        start_run(t0);
        k = 0;
        while (n_sent < 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("arst_pre_sends", 32'(n_sent), 32'd2);
        check("arst_pre_cmd",   32'(cmd),    32'(tour_cmd[1]));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count",    32'(count),    32'd0);
        check("arst_cmd",      32'(cmd),      32'd0);
        check("arst_send",     32'(send_cmd), 32'd0);
        check("arst_busy",     32'(busy),     32'd0);
        check("arst_done",     32'(done),     32'd0);
        check("arst_pass",     32'(pass),     32'd0);
        check("arst_err",      32'(err),      32'd0);
        check("arst_fail_idx", 32'(fail_idx), 32'd0);
        rsp_on = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
